// File: rtl/prbs7_checker.sv
// Self-synchronising PRBS7 (x^7+x^6+1) checker: seeds from the incoming stream,
// verifies the recurrence, then free-runs and counts bit errors while locked.
module prbs7_checker #(
   parameter int LOCK_COUNT  = 14,
   parameter int WINDOW      = 16,
   parameter int UNLOCK_ERRS = 4,
   parameter int ERR_WIDTH   = 7
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 valid,
   input  logic                 din,
   input  logic                 clear_errs,
   output logic                 locked,
   output logic                 err_pulse,
   output logic [ERR_WIDTH-1:0] err_count
);

   typedef enum logic [1:0] {SEED, VERIFY, LOCKED} state_t;

   localparam logic [7:0] LOCK_CNT8 = 8'(LOCK_COUNT);
   localparam logic [7:0] WINDOW8   = 8'(WINDOW);
   localparam logic [7:0] UNLOCK8   = 8'(UNLOCK_ERRS);

   state_t               state, state_n;
   logic [6:0]           hist, hist_n;
   logic [2:0]           seed_cnt, seed_cnt_n;
   logic [7:0]           match_cnt, match_cnt_n;
   logic [7:0]           win_bits, win_bits_n;
   logic [7:0]           win_errs, win_errs_n;
   logic                 locked_n, err_pulse_n;
   logic [ERR_WIDTH-1:0] err_count_n;

   logic       predicted, mismatch;
   logic [6:0] din_hist;
   logic [7:0] match_inc, win_bits_inc, win_errs_inc;

   // hist[6] is the oldest bit, so the next bit is b[n-7] ^ b[n-6].
   assign predicted    = hist[6] ^ hist[5];
   assign mismatch     = din ^ predicted;
   assign din_hist     = {hist[5:0], din};
   assign match_inc    = match_cnt + 8'd1;
   assign win_bits_inc = win_bits + 8'd1;
   assign win_errs_inc = win_errs + 8'd1;

   always_comb begin
      // NOTE: every next-state signal holds its value by default so no path
      // through the case statement can leave one unassigned and infer a latch.
      state_n     = state;
      hist_n      = hist;
      seed_cnt_n  = seed_cnt;
      match_cnt_n = match_cnt;
      win_bits_n  = win_bits;
      win_errs_n  = win_errs;
      locked_n    = locked;
      err_pulse_n = 1'b0;
      err_count_n = err_count;

      if (valid) begin
         case (state)
            SEED: begin
               hist_n = din_hist;
               if (seed_cnt == 3'd6) begin
                  seed_cnt_n = 3'd0;
                  // An all-zero history is the PRBS lock-up state; keep collecting.
                  if (din_hist != 7'd0) begin
                     state_n     = VERIFY;
                     match_cnt_n = 8'd0;
                  end
               end else begin
                  seed_cnt_n = seed_cnt + 3'd1;
               end
            end

            VERIFY: begin
               hist_n = din_hist;
               if (mismatch) begin
                  state_n    = SEED;
                  seed_cnt_n = 3'd0;
               end else if (match_inc == LOCK_CNT8) begin
                  state_n    = LOCKED;
                  locked_n   = 1'b1;
                  win_bits_n = 8'd0;
                  win_errs_n = 8'd0;
               end else begin
                  match_cnt_n = match_inc;
               end
            end

            LOCKED: begin
               // Free-run on the prediction so one flipped bit costs one error.
               hist_n = {hist[5:0], predicted};
               if (mismatch) begin
                  err_pulse_n = 1'b1;
                  if (err_count != '1)
                     err_count_n = err_count + ERR_WIDTH'(1);
               end
               if (mismatch && (win_errs_inc >= UNLOCK8)) begin
                  state_n    = SEED;
                  locked_n   = 1'b0;
                  seed_cnt_n = 3'd0;
                  win_bits_n = 8'd0;
                  win_errs_n = 8'd0;
               end else if (win_bits_inc == WINDOW8) begin
                  win_bits_n = 8'd0;
                  win_errs_n = 8'd0;
               end else begin
                  win_bits_n = win_bits_inc;
                  win_errs_n = mismatch ? win_errs_inc : win_errs;
               end
            end

            default: state_n = SEED;
         endcase
      end

      if (clear_errs)
         err_count_n = '0;
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (rst) begin
         state     <= SEED;
         hist      <= 7'd0;
         seed_cnt  <= 3'd0;
         match_cnt <= 8'd0;
         win_bits  <= 8'd0;
         win_errs  <= 8'd0;
         locked    <= 1'b0;
         err_pulse <= 1'b0;
         err_count <= '0;
      end else begin
         state     <= state_n;
         hist      <= hist_n;
         seed_cnt  <= seed_cnt_n;
         match_cnt <= match_cnt_n;
         win_bits  <= win_bits_n;
         win_errs  <= win_errs_n;
         locked    <= locked_n;
         err_pulse <= err_pulse_n;
         err_count <= err_count_n;
      end
   end

endmodule
